// File: rtl/be_arb_pkg.sv
// be_arb_pkg: shared state type and index-width helper for be_mem_arbiter.
package be_arb_pkg;

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// arb_rr_picker: combinational one-hot picker, scanning from base_i upward with wrap.
module arb_rr_picker
    import be_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] base_i,
    output logic [N-1:0]  pick_o,
    output logic          any_o
);

    logic          found;
    logic [IW-1:0] j;

    always_comb begin
        pick_o = '0;
        found  = 1'b0;
        j      = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(base_i) + k) % N);
            if (!found && req_i[j]) begin
                pick_o[j] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/be_mem_arbiter.sv
// be_mem_arbiter: one-transfer-per-grant arbiter sharing a native memory port.
// Define BE_ARB_RR_EN for round-robin; otherwise fixed priority with index 0 highest.
module be_mem_arbiter
    import be_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    localparam int NBYTES   = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*NBYTES-1:0]   m_wstrb,
    output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
    output logic [N_MASTERS-1:0]          m_ready,
    output logic                          mem_valid,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic [NBYTES-1:0]             mem_wstrb,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ready,
    output logic [N_MASTERS-1:0]          grant
);

    localparam int IW = idx_w(N_MASTERS);

    state_t                 state_q, state_d;
    logic [N_MASTERS-1:0]   grant_q, grant_d;
    logic [N_MASTERS-1:0]   pick;
    logic                   any;
    logic                   cur_valid;
    logic [IW-1:0]          base;

`ifdef BE_ARB_RR_EN
    logic [IW-1:0] last_q, last_d, gi;

    assign base = (last_q == IW'(N_MASTERS - 1)) ? '0 : last_q + 1'b1;

    always_comb begin
        gi = '0;
        for (int i = 0; i < N_MASTERS; i++)
            if (grant_q[i]) gi = IW'(i);
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) last_q <= IW'(N_MASTERS - 1);
        else       last_q <= last_d;
`else
    assign base = '0;
`endif

    arb_rr_picker #(.N(N_MASTERS), .IW(IW)) u_pick (
        .req_i  (m_valid),
        .base_i (base),
        .pick_o (pick),
        .any_o  (any)
    );

    assign cur_valid = |(m_valid & grant_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
`ifdef BE_ARB_RR_EN
        last_d  = last_q;
`endif
        if (state_q == IDLE) begin
            if (any) begin
                state_d = BUSY;
                grant_d = pick;
            end
        end else if (mem_ready || !cur_valid) begin
            state_d = IDLE;
            grant_d = '0;
`ifdef BE_ARB_RR_EN
            last_d  = gi;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end

    // grant_q is zero in IDLE, so the one-hot AND-OR mux drives zeros there
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        for (int i = 0; i < N_MASTERS; i++)
            if (grant_q[i]) begin
                mem_addr  = m_addr[i*ADDR_W +: ADDR_W];
                mem_wdata = m_wdata[i*DATA_W +: DATA_W];
                mem_wstrb = m_wstrb[i*NBYTES +: NBYTES];
            end
    end

    assign mem_valid = (state_q == BUSY) && cur_valid;
    assign m_ready   = grant_q & {N_MASTERS{mem_ready}};
    assign m_rdata   = {N_MASTERS{mem_rdata}};
    assign grant     = grant_q;

endmodule

// File: tb/tb_be_mem_arbiter.sv
// tb_be_mem_arbiter: directed self-checking bench for be_mem_arbiter with two requesters.
module tb_be_mem_arbiter;

    localparam int N = 2, AW = 32, DW = 32, NB = DW / 8;

    logic          clk = 1'b0, reset = 1'b1;
    logic [N-1:0]  m_valid = '0;
    logic [N*AW-1:0] m_addr = '0;
    logic [N*DW-1:0] m_wdata = '0;
    logic [N*NB-1:0] m_wstrb = '0;
    logic [N*DW-1:0] m_rdata;
    logic [N-1:0]  m_ready, grant;
    logic          mem_valid, mem_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata = '0;
    logic [NB-1:0] mem_wstrb;

    int total = 0, bad = 0;

    be_mem_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        m_valid = 2'b11;
        #2;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", grant); end
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
        total++; if (m_ready !== 2'b00) begin bad++; $display("FAIL reset_m_ready got=%b exp=00", m_ready); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        next_cycle();
        m_valid = 2'b00;
        reset = 1'b0;
    endtask

    task automatic test_single;
        m_valid = 2'b10;
        m_addr[AW +: AW] = 32'h100;
        m_wdata[DW +: DW] = 32'h1234_5678;
        m_wstrb[NB +: NB] = 4'hF;
        #1;
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL single_t0_valid got=%b exp=0", mem_valid); end
        next_cycle();
        total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL single_t1_valid got=%b exp=1", mem_valid); end
        total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL single_t1_addr got=%h exp=100", mem_addr); end
        total++; if (mem_wstrb !== 4'hF) begin bad++; $display("FAIL single_t1_wstrb got=%h exp=f", mem_wstrb); end
        total++; if (mem_wdata !== 32'h1234_5678) begin bad++; $display("FAIL single_t1_wdata got=%h exp=12345678", mem_wdata); end
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL single_t1_grant got=%b exp=10", grant); end
        next_cycle();
        total++; if (m_ready !== 2'b00) begin bad++; $display("FAIL single_t2_ready got=%b exp=00", m_ready); end
        next_cycle();
        mem_ready = 1'b1;
        #1;
        total++; if (m_ready !== 2'b10) begin bad++; $display("FAIL single_t3_ready got=%b exp=10", m_ready); end
        next_cycle();
        mem_ready = 1'b0;
        m_valid = 2'b00;
        #1;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL single_t4_grant got=%b exp=00", grant); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL single_t4_addr got=%h exp=0", mem_addr); end
    endtask

    task automatic test_contention;
        logic [1:0] exp_g, exp_r;
        m_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            mem_ready = k[0];
            if (!k[0]) exp_g = 2'b00;
`ifdef BE_ARB_RR_EN
            else exp_g = (k % 4 == 1) ? 2'b01 : 2'b10;
`else
            else exp_g = 2'b01;
`endif
            exp_r = k[0] ? exp_g : 2'b00;
            #1;
            total++; if (grant !== exp_g) begin bad++; $display("FAIL contention_grant k=%0d got=%b exp=%b", k, grant, exp_g); end
            total++; if (m_ready !== exp_r) begin bad++; $display("FAIL contention_ready k=%0d got=%b exp=%b", k, m_ready, exp_r); end
            next_cycle();
        end
        m_valid = 2'b00;
        mem_ready = 1'b0;
        next_cycle();
    endtask

    task automatic test_read;
        m_valid = 2'b01;
        m_addr[0 +: AW] = 32'h40;
        m_wstrb[0 +: NB] = 4'h0;
        next_cycle();
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL read_grant got=%b exp=01", grant); end
        total++; if (mem_wstrb !== 4'h0) begin bad++; $display("FAIL read_wstrb got=%h exp=0", mem_wstrb); end
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (m_rdata[0 +: DW] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_rdata got=%h exp=deadbeef", m_rdata[0 +: DW]); end
        total++; if (m_ready !== 2'b01) begin bad++; $display("FAIL read_ready got=%b exp=01", m_ready); end
        next_cycle();
        mem_ready = 1'b0;
        m_valid = 2'b00;
        next_cycle();
    endtask

    task automatic test_abort;
        m_valid = 2'b10;
        next_cycle();
        total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL abort_busy_valid got=%b exp=1", mem_valid); end
        m_valid = 2'b00;
        #1;
        total++; if (m_ready !== 2'b00) begin bad++; $display("FAIL abort_drop_ready got=%b exp=00", m_ready); end
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL abort_drop_valid got=%b exp=0", mem_valid); end
        next_cycle();
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL abort_idle_grant got=%b exp=00", grant); end
        total++; if (m_ready !== 2'b00) begin bad++; $display("FAIL abort_idle_ready got=%b exp=00", m_ready); end
    endtask

    task automatic test_reset_mid;
        m_valid = 2'b10;
        next_cycle();
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL rstmid_busy_grant got=%b exp=10", grant); end
        mem_ready = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL rstmid_grant got=%b exp=00", grant); end
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", mem_valid); end
        total++; if (m_ready !== 2'b00) begin bad++; $display("FAIL rstmid_ready got=%b exp=00", m_ready); end
        mem_ready = 1'b0;
        next_cycle();
        reset = 1'b0;
        m_valid = 2'b11;
        next_cycle();
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL rstmid_first_grant got=%b exp=01", grant); end
        m_valid = 2'b00;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_read();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
